// File: rtl/guess_round_controller.sv
// Purpose  : game-sequencing FSM for the number-guessing game (level/round/attempts, compare, win/lose).
// Latency  : guess sampled at edge N -> CHECK in cycle N+1 -> feedback flags from N+2 for RESULT_CYCLES cycles.
// Backpress: guess_ready high only in PLAY; guesses outside PLAY are dropped, never queued.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   start                             begin/restart pulse (IDLE, DONE only)
//   guess_valid, guess_digit_1..3     BCD guess (ones, tens, hundreds)
//   target_digit_1..3                 BCD target from the external lookup of Max_digit/round
//   Max_digit, round                  current level (active digit count) and round, both 1..3
//   guess_ready                       PLAY state indicator
//   too_high, too_low, correct        one-hot feedback while in SHOW
//   attempts                          wrong guesses in the current round
//   game_over, win                    end state and outcome
module guess_round_controller #(
  parameter int MAX_ATTEMPTS  = 7,
  parameter int ATT_W         = 4,
  parameter int RESULT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             guess_valid,
  input  logic [3:0]       guess_digit_1,
  input  logic [3:0]       guess_digit_2,
  input  logic [3:0]       guess_digit_3,
  input  logic [3:0]       target_digit_1,
  input  logic [3:0]       target_digit_2,
  input  logic [3:0]       target_digit_3,
  output logic [1:0]       Max_digit,
  output logic [1:0]       round,
  output logic             guess_ready,
  output logic             too_high,
  output logic             too_low,
  output logic             correct,
  output logic [ATT_W-1:0] attempts,
  output logic             game_over,
  output logic             win
);

  // Hold counter counts RESULT_CYCLES-1 down to 0, so SHOW lasts exactly RESULT_CYCLES cycles.
  localparam int               HOLD_W    = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_CYCLES - 1);
  localparam logic [ATT_W-1:0]  ATT_MAX   = ATT_W'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CHECK = 3'd2,
    S_SHOW  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RES_LOW  = 2'd0,
    RES_HIGH = 2'd1,
    RES_EQ   = 2'd2
  } res_t;

  state_t            state_q, state_d;
  logic [1:0]        level_q, level_d;
  logic [1:0]        round_q, round_d;
  logic [ATT_W-1:0]  att_q, att_d;
  logic [3:0]        g1_q, g1_d, g2_q, g2_d, g3_q, g3_d;
  res_t              res_q, res_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              win_q, win_d;

  logic              guess_bad;
  logic [3:0]        m2, m3;
  res_t              cmp_res;

  // Only digits inside the current level are checked for BCD validity;
  // inactive positions may carry anything since they are masked later.
  always_comb begin
    guess_bad = (guess_digit_1 > 4'd9)
              | ((level_q >= 2'd2) & (guess_digit_2 > 4'd9))
              | ((level_q == 2'd3) & (guess_digit_3 > 4'd9));
  end

  // Masked guess compared most-significant digit first; for BCD this equals numeric order.
  always_comb begin
    m2 = (level_q >= 2'd2) ? g2_q : 4'd0;
    m3 = (level_q == 2'd3) ? g3_q : 4'd0;
    if (m3 != target_digit_3) begin
      cmp_res = (m3 > target_digit_3) ? RES_HIGH : RES_LOW;
    end else if (m2 != target_digit_2) begin
      cmp_res = (m2 > target_digit_2) ? RES_HIGH : RES_LOW;
    end else if (g1_q != target_digit_1) begin
      cmp_res = (g1_q > target_digit_1) ? RES_HIGH : RES_LOW;
    end else begin
      cmp_res = RES_EQ;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    round_d = round_q;
    att_d   = att_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    g3_d    = g3_q;
    res_d   = res_q;
    hold_d  = hold_q;
    win_d   = win_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          level_d = 2'd1;
          round_d = 2'd1;
          att_d   = '0;
          win_d   = 1'b0;
          state_d = S_PLAY;
        end
      end

      S_PLAY: begin
        if (guess_valid && !guess_bad) begin
          g1_d    = guess_digit_1;
          g2_d    = guess_digit_2;
          g3_d    = guess_digit_3;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        res_d  = cmp_res;
        hold_d = HOLD_LAST;
        if ((cmp_res != RES_EQ) && (att_q != ATT_MAX)) begin
          att_d = att_q + 1'b1;
        end
        state_d = S_SHOW;
      end

      S_SHOW: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (res_q == RES_EQ) begin
          state_d = S_NEXT;
        end else if (att_q == ATT_MAX) begin
          win_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_PLAY;
        end
      end

      S_NEXT: begin
        att_d = '0;
        if (round_q != 2'd3) begin
          round_d = round_q + 2'd1;
          state_d = S_PLAY;
        end else if (level_q != 2'd3) begin
          round_d = 2'd1;
          level_d = level_q + 2'd1;
          state_d = S_PLAY;
        end else begin
          // Final round of final level solved: level/round stay at 3/3.
          win_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 2'd1;
      round_q <= 2'd1;
      att_q   <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      g3_q    <= '0;
      res_q   <= RES_LOW;
      hold_q  <= '0;
      win_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      round_q <= round_d;
      att_q   <= att_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      g3_q    <= g3_d;
      res_q   <= res_d;
      hold_q  <= hold_d;
      win_q   <= win_d;
    end
  end

  assign Max_digit   = level_q;
  assign round       = round_q;
  assign attempts    = att_q;
  assign guess_ready = (state_q == S_PLAY);
  assign too_high    = (state_q == S_SHOW) && (res_q == RES_HIGH);
  assign too_low     = (state_q == S_SHOW) && (res_q == RES_LOW);
  assign correct     = (state_q == S_SHOW) && (res_q == RES_EQ);
  assign game_over   = (state_q == S_DONE);
  assign win         = (state_q == S_DONE) && win_q;

endmodule

// File: tb/tb_guess_round_controller.sv
// Purpose  : randomized bench for guess_round_controller against a numeric game model.
// Latency  : expects flags two cycles after the guess edge, held four cycles.
// Backpress: drives guesses only when guess_ready is seen high.
module tb_guess_round_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       guess_valid = 1'b0;
  logic [3:0] guess_digit_1 = '0, guess_digit_2 = '0, guess_digit_3 = '0;
  logic [3:0] target_digit_1, target_digit_2, target_digit_3;
  logic [1:0] Max_digit, round;
  logic       guess_ready, too_high, too_low, correct, game_over, win;
  logic [3:0] attempts;

  int checks = 0;
  int errors = 0;

  // Game model: plain integers for level, round, wrong-guess count and outcome.
  int targets [9] = '{2, 8, 3, 57, 96, 21, 123, 0, 999};
  int lvl = 1, rnd = 1, att = 0;
  bit over = 0, won = 0;

  always #5 clk = ~clk;

  guess_round_controller #(.MAX_ATTEMPTS(7), .ATT_W(4), .RESULT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .guess_valid(guess_valid),
    .guess_digit_1(guess_digit_1), .guess_digit_2(guess_digit_2), .guess_digit_3(guess_digit_3),
    .target_digit_1(target_digit_1), .target_digit_2(target_digit_2), .target_digit_3(target_digit_3),
    .Max_digit(Max_digit), .round(round), .guess_ready(guess_ready),
    .too_high(too_high), .too_low(too_low), .correct(correct),
    .attempts(attempts), .game_over(game_over), .win(win)
  );

  // Combinational target lookup keyed by the DUT's level/round.
  always_comb begin
    int t;
    t = 0;
    if (Max_digit >= 2'd1 && Max_digit <= 2'd3 && round >= 2'd1 && round <= 2'd3)
      t = targets[(int'(Max_digit) - 1) * 3 + int'(round) - 1];
    target_digit_1 = 4'(t % 10);
    target_digit_2 = 4'((t / 10) % 10);
    target_digit_3 = 4'(t / 100);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int cur_target();
    return targets[(lvl - 1) * 3 + rnd - 1];
  endfunction

  // Build a guess for the current round: exact target or a random wrong value,
  // with random junk in the digit positions the current level does not use.
  task automatic pick(input bit right, output logic [3:0] d3, output logic [3:0] d2, output logic [3:0] d1);
    int span, v;
    span = (lvl == 1) ? 10 : (lvl == 2) ? 100 : 1000;
    if (right) v = cur_target();
    else begin
      do v = int'($urandom_range(span - 1, 0)); while (v == cur_target());
    end
    d1 = 4'(v % 10);
    d2 = (lvl >= 2) ? 4'((v / 10) % 10) : 4'($urandom_range(15, 0));
    d3 = (lvl == 3) ? 4'(v / 100) : 4'($urandom_range(15, 0));
  endtask

  task automatic model_reset();
    lvl = 1; rnd = 1; att = 0; over = 0; won = 0;
  endtask

  task automatic play_guess(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1);
    bit bad, hi, lo, eq;
    int v, steps;
    bad = (d1 > 9) || (lvl >= 2 && d2 > 9) || (lvl == 3 && d3 > 9);
    v = int'(d1) + ((lvl >= 2) ? 10 * int'(d2) : 0) + ((lvl == 3) ? 100 * int'(d3) : 0);
    hi = v > cur_target(); lo = v < cur_target(); eq = v == cur_target();
    checks++;
    if (guess_ready !== 1'b1) begin
      errors++; $display("FAIL ready_before_guess: got %b want 1", guess_ready);
    end
    guess_digit_3 = d3; guess_digit_2 = d2; guess_digit_1 = d1; guess_valid = 1'b1;
    @(negedge clk);
    guess_valid = 1'b0;
    if (bad) begin
      repeat (2) begin
        checks++;
        if (guess_ready !== 1'b1 || {too_high, too_low, correct} !== 3'b000 || attempts !== 4'(att)) begin
          errors++;
          $display("FAIL reject: ready=%b flags=%b attempts=%0d want ready=1 flags=000 attempts=%0d",
                   guess_ready, {too_high, too_low, correct}, attempts, att);
        end
        @(negedge clk);
      end
      return;
    end
    checks++;
    if (guess_ready !== 1'b0 || {too_high, too_low, correct} !== 3'b000) begin
      errors++;
      $display("FAIL check_cycle: ready=%b flags=%b want ready=0 flags=000", guess_ready, {too_high, too_low, correct});
    end
    if (!eq && att < 7) att++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({too_high, too_low, correct} !== {hi, lo, eq} || attempts !== 4'(att)) begin
        errors++;
        $display("FAIL show[%0d] guess=%0d target=%0d: flags=%b attempts=%0d want flags=%b attempts=%0d",
                 i, v, cur_target(), {too_high, too_low, correct}, attempts, {hi, lo, eq}, att);
      end
    end
    @(negedge clk);
    checks++;
    if ({too_high, too_low, correct} !== 3'b000) begin
      errors++; $display("FAIL show_end: flags=%b want 000", {too_high, too_low, correct});
    end
    if (eq) begin
      att = 0;
      if (rnd < 3) rnd++;
      else if (lvl < 3) begin lvl++; rnd = 1; end
      else begin over = 1; won = 1; end
    end else if (att == 7) begin
      over = 1; won = 0;
    end
    steps = 0;
    while (!(guess_ready === 1'b1 || game_over === 1'b1) && steps < 5) begin
      @(negedge clk); steps++;
    end
    checks++;
    if (steps >= 5) begin
      errors++; $display("FAIL settle_timeout: no PLAY/DONE within 5 cycles");
    end
    checks++;
    if (Max_digit !== 2'(lvl) || round !== 2'(rnd) || attempts !== 4'(att) ||
        game_over !== over || win !== won || guess_ready !== !over) begin
      errors++;
      $display("FAIL after_guess: lvl=%0d rnd=%0d att=%0d over=%b win=%b ready=%b want %0d %0d %0d %b %b %b",
               Max_digit, round, attempts, game_over, win, guess_ready, lvl, rnd, att, over, won, !over);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; guess_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (Max_digit !== 2'd1 || round !== 2'd1 || attempts !== 4'd0 || guess_ready !== 1'b0 ||
        {too_high, too_low, correct} !== 3'b000 || game_over !== 1'b0 || win !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: lvl=%0d rnd=%0d att=%0d ready=%b flags=%b over=%b win=%b",
               Max_digit, round, attempts, guess_ready, {too_high, too_low, correct}, game_over, win);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // start together with a would-be-correct guess in IDLE: start wins, guess dropped.
  task automatic test_start();
    start = 1'b1; guess_valid = 1'b1;
    guess_digit_3 = 4'd0; guess_digit_2 = 4'd0; guess_digit_1 = 4'd2;
    @(negedge clk);
    start = 1'b0; guess_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (guess_ready !== 1'b1 || {too_high, too_low, correct} !== 3'b000 || round !== 2'd1) begin
        errors++;
        $display("FAIL start_drops_guess[%0d]: ready=%b flags=%b round=%0d want 1 000 1",
                 i, guess_ready, {too_high, too_low, correct}, round);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    play_guess(4'd0, 4'd0, 4'd2);   // L1R1 correct
    play_guess(4'd0, 4'd0, 4'd5);   // L1R2 too low
    play_guess(4'd0, 4'd0, 4'd9);   // too high
    play_guess(4'd0, 4'd0, 4'd8);   // correct -> L1R3
  endtask

  task automatic test_masking();
    test_reset(); test_start();
    play_guess(4'd0, 4'd0, 4'hA);   // active digit not BCD: rejected
    play_guess(4'd7, 4'd4, 4'd2);   // upper digits masked: correct
    play_guess(4'hF, 4'hF, 4'd3);   // non-BCD in inactive positions accepted
  endtask

  task automatic test_lose();
    logic [3:0] a, b, c;
    test_reset(); test_start();
    for (int i = 0; i < 7; i++) begin
      pick(1'b0, a, b, c);
      play_guess(a, b, c);
      if (i == 3) begin
        // start outside IDLE/DONE must not disturb the round
        start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
        checks++;
        if (guess_ready !== 1'b1 || attempts !== 4'(att) || round !== 2'(rnd)) begin
          errors++;
          $display("FAIL start_in_play: ready=%b att=%0d rnd=%0d want 1 %0d %0d", guess_ready, attempts, round, att, rnd);
        end
      end
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    model_reset();
    checks++;
    if (guess_ready !== 1'b1 || game_over !== 1'b0 || Max_digit !== 2'd1 || round !== 2'd1 || attempts !== 4'd0) begin
      errors++;
      $display("FAIL restart_after_lose: ready=%b over=%b lvl=%0d rnd=%0d att=%0d want 1 0 1 1 0",
               guess_ready, game_over, Max_digit, round, attempts);
    end
  endtask

  task automatic test_win();
    logic [3:0] a, b, c;
    test_reset(); test_start();
    for (int r = 0; r < 9; r++) begin
      int n;
      n = int'($urandom_range(3, 0));
      for (int k = 0; k < n; k++) begin
        pick(1'b0, a, b, c);
        play_guess(a, b, c);
      end
      pick(1'b1, a, b, c);
      play_guess(a, b, c);
    end
    checks++;
    if (game_over !== 1'b1 || win !== 1'b1 || Max_digit !== 2'd3 || round !== 2'd3) begin
      errors++;
      $display("FAIL win_end: over=%b win=%b lvl=%0d rnd=%0d want 1 1 3 3", game_over, win, Max_digit, round);
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    model_reset();
    checks++;
    if (game_over !== 1'b0 || win !== 1'b0 || guess_ready !== 1'b1 || Max_digit !== 2'd1 || round !== 2'd1) begin
      errors++;
      $display("FAIL restart_after_win: over=%b win=%b ready=%b lvl=%0d rnd=%0d want 0 0 1 1 1",
               game_over, win, guess_ready, Max_digit, round);
    end
  endtask

  task automatic test_reset_mid_show();
    test_reset(); test_start();
    play_guess(4'd0, 4'd0, 4'd2);   // -> L1R2
    guess_digit_1 = 4'd1; guess_valid = 1'b1;
    @(negedge clk); guess_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (too_low !== 1'b1 || attempts !== 4'd1 || round !== 2'd2) begin
      errors++; $display("FAIL pre_reset_show: too_low=%b att=%0d rnd=%0d want 1 1 2", too_low, attempts, round);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({too_high, too_low, correct} !== 3'b000 || guess_ready !== 1'b0 || Max_digit !== 2'd1 ||
        round !== 2'd1 || attempts !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: flags=%b ready=%b lvl=%0d rnd=%0d att=%0d want 000 0 1 1 0",
               {too_high, too_low, correct}, guess_ready, Max_digit, round, attempts);
    end
    @(negedge clk); reset_n = 1'b1;
    guess_digit_1 = 4'd2; guess_valid = 1'b1;
    @(negedge clk); guess_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (guess_ready !== 1'b0 || {too_high, too_low, correct} !== 3'b000 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL guess_in_idle: ready=%b flags=%b over=%b want 0 000 0",
               guess_ready, {too_high, too_low, correct}, game_over);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_basic();
    test_masking();
    test_lose();
    test_win();
    test_reset_mid_show();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
